// File: rtl/dac_frame_packer.sv
// dac_frame_packer: packs 16-bit DMA samples into 256-bit DAC frames through a small frame FIFO.
// Optional underrun counter is built only when DAC_PACKER_UNDERRUN_CNT_EN is defined.
module dac_frame_packer #(
  parameter int SAMPLE_W   = 16,
  parameter int LANES      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [SAMPLE_W-1:0]           s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic                          s_axis_tlast,
  output logic                          s_axis_tready,
  output logic [SAMPLE_W*LANES-1:0]     m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [31:0]                   underrun_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int FW = SAMPLE_W * LANES;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int IW = $clog2(LANES);
  localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] PRIME_LVL = LW'(2);
  typedef enum logic [1:0] {OFF, PRIME, STREAM} state_t;
  state_t        state_q, state_d;
  logic [IW-1:0] lane_q, lane_d;
  logic [FW-1:0] part_q, part_d, frame_w, data_q, data_d;
  logic [FW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q, level_d;
  logic          rdy_q, vld_q, acc, push, pop;
  // a beat is taken only while running; a frame closes on the last lane or on tlast
  assign acc  = s_axis_tvalid & rdy_q & enable;
  assign push = acc & (s_axis_tlast | (lane_q == IW'(LANES-1)));
  assign pop  = enable & (state_q == STREAM) & m_axis_tready & (level_q != '0);
  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = vld_q;
  assign m_axis_tdata  = data_q;
  assign fifo_level    = level_q;
  // merge the incoming sample into its lane; unwritten lanes stay zero because the partial frame is cleared after each push
  always_comb begin
    for (int i = 0; i < LANES; i++)
      frame_w[i*SAMPLE_W +: SAMPLE_W] = (lane_q == IW'(i)) ? s_axis_tdata : part_q[i*SAMPLE_W +: SAMPLE_W];
  end
  // run-state sequencing: OFF on disable, prime until two frames are buffered, then stream
  always_comb begin
    state_d = state_q;
    if (!enable) state_d = OFF;
    else if (state_q == OFF) state_d = PRIME;
    else if (state_q == PRIME && level_d >= PRIME_LVL) state_d = STREAM;
  end
  // packing, FIFO occupancy and output-register next values; disable flushes everything
  always_comb begin
    lane_d  = (!enable || push) ? '0 : acc ? lane_q + 1'b1 : lane_q;
    part_d  = (!enable || push) ? '0 : acc ? frame_w : part_q;
    level_d = !enable ? '0 : level_q + LW'(push) - LW'(pop);
    data_d  = (!enable || state_q != STREAM) ? '0 : pop ? mem_q[rd_q] : m_axis_tready ? '0 : data_q;
  end
  // control and datapath state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OFF;
      lane_q  <= '0;
      part_q  <= '0;
      data_q  <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      part_q  <= part_d;
      data_q  <= data_d;
      wr_q    <= !enable ? '0 : push ? wr_q + 1'b1 : wr_q;
      rd_q    <= !enable ? '0 : pop ? rd_q + 1'b1 : rd_q;
      level_q <= level_d;
      rdy_q   <= enable & (level_d < FULL);
      vld_q   <= 1'b1;
    end
  end
  // frame storage needs no reset: occupancy is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= frame_w;
  end
`ifdef DAC_PACKER_UNDERRUN_CNT_EN
  logic        starve;
  logic [31:0] cnt_q, cnt_d;
  assign starve = enable & (state_q == STREAM) & m_axis_tready & (level_q == '0);
  // clear on the enable rising edge, saturating count of inserted zero frames
  always_comb begin
    cnt_d = (state_q == OFF && enable) ? '0 : (starve && ~&cnt_q) ? cnt_q + 32'd1 : cnt_q;
  end
  // underrun counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign underrun_count = cnt_q;
`else
  assign underrun_count = '0;
`endif
endmodule

// File: tb/tb_dac_frame_packer.sv
// tb_dac_frame_packer: directed self-checking bench for dac_frame_packer.
module tb_dac_frame_packer;
`ifdef DAC_PACKER_UNDERRUN_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic         clk = 1'b0, rst = 1'b1, enable = 1'b0;
  logic [15:0]  s_data = '0;
  logic         s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic         s_axis_tready, m_axis_tvalid;
  logic [255:0] m_axis_tdata;
  logic [31:0]  underrun_count;
  logic [2:0]   fifo_level;
  int nvec = 0, nerr = 0;
  dac_frame_packer dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_ready),
    .underrun_count(underrun_count), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask
  function automatic logic [255:0] mk(input logic [15:0] base, input int n);
    mk = '0;
    for (int i = 0; i < n; i++) mk[16*i +: 16] = base + 16'(i);
  endfunction
  function automatic logic [31:0] uc(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [15:0] d, input logic l);
    int w;
    s_data = d;
    s_valid = 1'b1;
    s_last = l;
    w = 0;
    while (!s_axis_tready && w < 20) begin
      tick();
      w++;
    end
    if (!s_axis_tready) chk("send_ready_timeout", 256'(s_axis_tready), 256'(1));
    tick();
    s_last = 1'b0;
  endtask
  task automatic burst(input logic [15:0] base, input int n, input logic l);
    for (int i = 0; i < n; i++) send(base + 16'(i), l && (i == n - 1));
    s_valid = 1'b0;
  endtask
  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_tvalid", 256'(m_axis_tvalid), 256'(0));
    chk("rst_tready", 256'(s_axis_tready), 256'(0));
    chk("rst_tdata", m_axis_tdata, '0);
    chk("rst_level", 256'(fifo_level), 256'(0));
    chk("rst_ucnt", 256'(underrun_count), 256'(0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("off_tvalid", 256'(m_axis_tvalid), 256'(1));
    chk("off_tdata", m_axis_tdata, '0);
    chk("off_tready", 256'(s_axis_tready), 256'(0));
    // two full frames of 0x0001..0x0020
    enable = 1'b1;
    tick();
    chk("en_tready", 256'(s_axis_tready), 256'(1));
    burst(16'h0001, 16, 1'b0);
    chk("t1_level1", 256'(fifo_level), 256'(1));
    burst(16'h0011, 16, 1'b0);
    chk("t1_level2", 256'(fifo_level), 256'(2));
    chk("t1_prezero", m_axis_tdata, '0);
    chk("t1_ucnt0", 256'(underrun_count), 256'(0));
    tick();
    chk("t1_frame0", m_axis_tdata, mk(16'h0001, 16));
    chk("t1_level_pop", 256'(fifo_level), 256'(1));
    tick();
    chk("t1_frame1", m_axis_tdata, mk(16'h0011, 16));
    chk("t1_ucnt_drain", 256'(underrun_count), 256'(0));
    tick();
    chk("t1_ur_data", m_axis_tdata, '0);
    chk("t1_ucnt1", 256'(underrun_count), 256'(uc(1)));
    tick();
    chk("t1_ucnt2", 256'(underrun_count), 256'(uc(2)));
    // full frame followed by a 5-sample tlast frame
    m_ready = 1'b0;
    burst(16'hB000, 16, 1'b0);
    burst(16'hA000, 5, 1'b1);
    chk("t2_level", 256'(fifo_level), 256'(2));
    chk("t2_ucnt_stall", 256'(underrun_count), 256'(uc(2)));
    m_ready = 1'b1;
    tick();
    chk("t2_full", m_axis_tdata, mk(16'hB000, 16));
    tick();
    chk("t2_tlast", m_axis_tdata, mk(16'hA000, 5));
    tick();
    chk("t2_zero", m_axis_tdata, '0);
    chk("t2_ucnt3", 256'(underrun_count), 256'(uc(3)));
    // backpressure: fill the FIFO, ready must drop at four frames
    m_ready = 1'b0;
    burst(16'h1000, 64, 1'b0);
    chk("t3_full_level", 256'(fifo_level), 256'(4));
    chk("t3_full_rdy", 256'(s_axis_tready), 256'(0));
    s_data = 16'h1040;
    s_valid = 1'b1;
    tick();
    tick();
    chk("t3_stall_rdy", 256'(s_axis_tready), 256'(0));
    chk("t3_stall_level", 256'(fifo_level), 256'(4));
    chk("t3_stall_data", m_axis_tdata, '0);
    s_valid = 1'b0;
    m_ready = 1'b1;
    tick();
    chk("t3_f0", m_axis_tdata, mk(16'h1000, 16));
    chk("t3_f0_level", 256'(fifo_level), 256'(3));
    chk("t3_rdy_back", 256'(s_axis_tready), 256'(1));
    m_ready = 1'b0;
    tick();
    chk("t3_hold", m_axis_tdata, mk(16'h1000, 16));
    chk("t3_hold_level", 256'(fifo_level), 256'(3));
    m_ready = 1'b1;
    tick();
    chk("t3_f1", m_axis_tdata, mk(16'h1010, 16));
    tick();
    chk("t3_f2", m_axis_tdata, mk(16'h1020, 16));
    tick();
    chk("t3_f3", m_axis_tdata, mk(16'h1030, 16));
    chk("t3_empty", 256'(fifo_level), 256'(0));
    tick();
    chk("t3_ur", m_axis_tdata, '0);
    chk("t3_ucnt4", 256'(underrun_count), 256'(uc(4)));
    m_ready = 1'b0;
    burst(16'h1040, 16, 1'b0);
    chk("t3_rest_level", 256'(fifo_level), 256'(1));
    m_ready = 1'b1;
    tick();
    chk("t3_f4", m_axis_tdata, mk(16'h1040, 16));
    chk("t3_ucnt_keep", 256'(underrun_count), 256'(uc(4)));
    // disable mid-frame, then re-enable
    m_ready = 1'b0;
    burst(16'hC000, 16, 1'b0);
    burst(16'hD000, 7, 1'b0);
    m_ready = 1'b1;
    tick();
    chk("t4_fc", m_axis_tdata, mk(16'hC000, 16));
    enable = 1'b0;
    tick();
    chk("t4_off_data", m_axis_tdata, '0);
    chk("t4_off_valid", 256'(m_axis_tvalid), 256'(1));
    chk("t4_off_rdy", 256'(s_axis_tready), 256'(0));
    chk("t4_off_ucnt", 256'(underrun_count), 256'(uc(4)));
    tick();
    chk("t4_off_hold", 256'(underrun_count), 256'(uc(4)));
    enable = 1'b1;
    tick();
    chk("t4_re_rdy", 256'(s_axis_tready), 256'(1));
    chk("t4_re_ucnt", 256'(underrun_count), 256'(0));
    burst(16'hE000, 16, 1'b0);
    burst(16'hF000, 3, 1'b1);
    chk("t4_level", 256'(fifo_level), 256'(2));
    tick();
    chk("t4_clean", m_axis_tdata, mk(16'hE000, 16));
    tick();
    chk("t4_short", m_axis_tdata, mk(16'hF000, 3));
    chk("t4_ucnt", 256'(underrun_count), 256'(0));
    // asynchronous reset with three frames buffered
    m_ready = 1'b0;
    burst(16'h2000, 48, 1'b0);
    chk("t5_level3", 256'(fifo_level), 256'(3));
    chk("t5_hold", m_axis_tdata, mk(16'hF000, 3));
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_data", m_axis_tdata, '0);
    chk("t5_rst_valid", 256'(m_axis_tvalid), 256'(0));
    chk("t5_rst_rdy", 256'(s_axis_tready), 256'(0));
    chk("t5_rst_level", 256'(fifo_level), 256'(0));
    enable = 1'b0;
    #2 rst = 1'b1;
    tick();
    chk("t5_off_valid", 256'(m_axis_tvalid), 256'(1));
    chk("t5_off_level", 256'(fifo_level), 256'(0));
    chk("t5_off_rdy", 256'(s_axis_tready), 256'(0));
    // starve the FIFO for ten cycles
    m_ready = 1'b1;
    enable = 1'b1;
    tick();
    burst(16'h3000, 16, 1'b0);
    burst(16'h3010, 16, 1'b0);
    tick();
    chk("t6_f0", m_axis_tdata, mk(16'h3000, 16));
    tick();
    chk("t6_f1", m_axis_tdata, mk(16'h3010, 16));
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t6_zero%0d", i), m_axis_tdata, '0);
      chk($sformatf("t6_ucnt%0d", i), 256'(underrun_count), 256'(uc(i + 1)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
